// File: rtl/wallace_cpa_serial_pkg.sv
// wallace_cpa_serial_pkg: FSM state encodings and a constant log2 helper
package wallace_cpa_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wallace_cpa_serial_if.sv
// wallace_cpa_serial_if: operand/result handshake bundle
//   in_valid/in_ready + sum_vec/carry_vec : operand pair, master -> slave
//   out_valid/out_ready + product/ovf     : resolved sum, slave -> master
interface wallace_cpa_serial_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;
    logic             ovf;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, product, ovf
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, product, ovf
    );
endinterface

// File: rtl/wallace_cpa_serial_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple chain of full adders
//   a, b  : DIGIT-bit addend digits
//   c_in  : carry into bit 0
//   s     : DIGIT-bit sum digit
//   c_out : carry out of bit DIGIT-1
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module digit_adder #(parameter int DIGIT = 4) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] s,
    output logic             c_out
);
    logic [DIGIT:0] c;

    assign c[0]  = c_in;
    assign c_out = c[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .c_in (c[i]),
            .s    (s[i]),
            .c_out(c[i+1])
        );
    end
endmodule

// File: rtl/wallace_cpa_serial.sv
// wallace_cpa_serial: digit-serial carry-propagate adder resolving sum/carry vectors
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of wallace_cpa_serial_if; product = (sum_vec + carry_vec) mod 2^WIDTH,
//         ovf = carry out of the top bit, result valid WIDTH/DIGIT cycles after accept
module wallace_cpa_serial
    import wallace_cpa_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    wallace_cpa_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = clog2(NDIG) > 0 ? clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_n;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] s;
    logic             carry, c_out, last;

    digit_adder #(.DIGIT(DIGIT)) u_add (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .c_in (carry),
        .s    (s),
        .c_out(c_out)
    );

    // Sum digits enter at the top so the full result is aligned after NDIG shifts.
    assign res_n        = (res_sh >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
    assign last         = cnt == CW'(NDIG - 1);
    assign bus.in_ready = state == ST_IDLE && !rst;

    always_ff @(posedge clk)
        if (rst) state <= ST_IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = bus.in_valid ? ST_RUN : ST_IDLE;
            ST_RUN:  state_n = last ? ST_HOLD : ST_RUN;
            ST_HOLD: state_n = bus.out_ready ? ST_IDLE : ST_HOLD;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.product   <= '0;
            bus.ovf       <= 1'b0;
            carry         <= 1'b0;
            cnt           <= '0;
            a_sh          <= '0;
            b_sh          <= '0;
            res_sh        <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    a_sh  <= bus.sum_vec;
                    b_sh  <= bus.carry_vec;
                    carry <= 1'b0;
                    cnt   <= '0;
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_n;
                    carry  <= c_out;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        bus.product   <= res_n;
                        bus.ovf       <= c_out;
                        bus.out_valid <= 1'b1;
                    end
                end
                ST_HOLD: if (bus.out_ready) bus.out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wallace_cpa_serial.sv
// tb_wallace_cpa_serial: directed vectors on DIGIT=4, random sweeps on DIGIT=1 and DIGIT=16
module tb_wallace_cpa_serial;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       iv, ordy, ir, ov, of;
    logic [2:0][15:0] sv, cv, pr;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int D = (k == 0) ? 4 : (k == 1) ? 1 : 16;
        wallace_cpa_serial_if #(.WIDTH(16)) bus ();
        assign bus.in_valid  = iv[k];
        assign bus.sum_vec   = sv[k];
        assign bus.carry_vec = cv[k];
        assign bus.out_ready = ordy[k];
        assign ir[k]         = bus.in_ready;
        assign ov[k]         = bus.out_valid;
        assign pr[k]         = bus.product;
        assign of[k]         = bus.ovf;
        wallace_cpa_serial #(.WIDTH(16), .DIGIT(D)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    typedef struct {
        logic [15:0] a, b, p;
        logic        o;
        int          hold;
        bit          early, pulse;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // One complete transaction on DUT k, starting and ending at a negedge.
    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input logic o, input int lat_exp,
                         input int hold, input bit early, input bit pulse, input string nm);
        int lat;
        chk({nm, " in_ready idle"}, ir[k], 1);
        iv[k] = 1'b1; sv[k] = a; cv[k] = b; ordy[k] = early;
        @(negedge clk);
        iv[k] = 1'b0; sv[k] = 16'h0; cv[k] = 16'h0;
        lat = 0;
        while (!ov[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, lat_exp);
        chk({nm, " product"}, pr[k], p);
        chk({nm, " ovf"}, of[k], o);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({nm, " hold valid"}, ov[k], 1);
                chk({nm, " hold product"}, {of[k], pr[k]}, {o, p});
                chk({nm, " hold in_ready"}, ir[k], 0);
                iv[k] = pulse && h == 1;
                sv[k] = 16'hDEAD; cv[k] = 16'hBEEF;
            end
            iv[k] = 1'b0;
            ordy[k] = 1'b1;
        end
        @(negedge clk);
        ordy[k] = 1'b0;
        chk({nm, " valid drop"}, ov[k], 0);
        chk({nm, " in_ready back"}, ir[k], 1);
        chk({nm, " product kept"}, {of[k], pr[k]}, {o, p});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b;
        logic [16:0] s;
        tbl[0] = '{16'h1234, 16'h0F0F, 16'h2143, 1'b0, 0, 0, 0};
        tbl[1] = '{16'h0FFF, 16'h0001, 16'h1000, 1'b0, 0, 0, 0};
        tbl[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, 0, 0};
        tbl[3] = '{16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 5, 0, 1};
        tbl[4] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 2, 0, 0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 0, 1, 0};
        tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1, 0, 0};
        tbl[7] = '{16'h7FFF, 16'h8001, 16'h0000, 1'b1, 3, 1, 0};

        rst = 1'b1; iv = '0; ordy = '0; sv = '0; cv = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", ir[0], 0);
        chk("reset valid", ov[0], 0);
        chk("reset product", pr[0], 0);
        chk("reset ovf", of[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release in_ready", ir[0], 1);

        for (int i = 0; i < 8; i++)
            do_op(0, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].o, 4,
                  tbl[i].hold, tbl[i].early, tbl[i].pulse, $sformatf("vec%0d", i));

        // Abandon an operation with reset during its second RUN cycle.
        iv[0] = 1'b1; sv[0] = 16'h1111; cv[0] = 16'h2222;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort valid", ov[0], 0);
        chk("abort product", pr[0], 0);
        chk("abort in_ready rst", ir[0], 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort no valid", ov[0], 0);
        end
        do_op(0, 16'h00FF, 16'h00FF, 16'h01FE, 1'b0, 4, 1, 0, 0, "after abort");

        for (int k = 1; k < 3; k++)
            for (int n = 0; n < 1000; n++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                s = {1'b0, a} + {1'b0, b};
                do_op(k, a, b, s[15:0], s[16], k == 1 ? 16 : 1, $urandom_range(0, 3),
                      bit'($urandom_range(0, 1)), 0, $sformatf("sweep d%0d", k == 1 ? 1 : 16));
            end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
